// File: rtl/bist_pkg.sv
// Shared types and constants for the per-scan BIST response side.
package bist_pkg;
  localparam int RESP_W = 9;
  localparam int CNT_W  = 6;

  localparam logic [15:0] DEF_MISR_POLY = 16'h8016;
  localparam logic [15:0] DEF_MISR_SEED = 16'h0000;

  typedef enum logic [2:0] {IDLE, SETTLE, COMPACT, COMPARE, DONE} state_t;

  // Field order sets the MISR input bit order: test_out[0] lands on bit 0.
  typedef struct packed {
    logic       fz_l;
    logic       lclk;
    logic [4:0] read_a;
    logic [1:0] test_out;
  } resp_t;
endpackage

// File: rtl/bist_response_analyzer_if.sv
// Controller/CUT-facing bundle of the response analyzer.
interface bist_response_analyzer_if #(parameter int MISR_W = 16) ();
  import bist_pkg::*;

  logic              start;
  logic              resp_valid;
  logic              cut_fz_L;
  logic              cut_lclk;
  logic [4:0]        cut_read_a;
  logic [1:0]        cut_test_out;
  logic              busy;
  logic              done;
  logic              pass_nfail;
  logic [MISR_W-1:0] signature;
  logic [CNT_W-1:0]  pattern_cnt;

  modport master (
    output start, resp_valid, cut_fz_L, cut_lclk, cut_read_a, cut_test_out,
    input  busy, done, pass_nfail, signature, pattern_cnt
  );

  modport slave (
    input  start, resp_valid, cut_fz_L, cut_lclk, cut_read_a, cut_test_out,
    output busy, done, pass_nfail, signature, pattern_cnt
  );
endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift left, fold MSB back through POLY, XOR in data.
module bist_misr
  import bist_pkg::*;
#(
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = DEF_MISR_POLY,
  parameter logic [MISR_W-1:0] MISR_SEED = DEF_MISR_SEED
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              shift_en,
  input  logic [RESP_W-1:0] data_in,
  output logic [MISR_W-1:0] sig
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        sig <= MISR_SEED;
    else if (load)     sig <= MISR_SEED;
    else if (shift_en) sig <= {sig[MISR_W-2:0], 1'b0}
                            ^ (sig[MISR_W-1] ? MISR_POLY : '0)
                            ^ MISR_W'(data_in);
  end

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: settles, compacts N_PATTERNS qualified CUT responses, then
// compares the signature to GOLDEN_SIG and holds the verdict until the next start.
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int                N_PATTERNS    = 30,
  parameter int                SETTLE_CYCLES = 1,
  parameter int                MISR_W        = 16,
  parameter logic [MISR_W-1:0] MISR_POLY     = DEF_MISR_POLY,
  parameter logic [MISR_W-1:0] MISR_SEED     = DEF_MISR_SEED,
  parameter logic [MISR_W-1:0] GOLDEN_SIG    = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  bist_response_analyzer_if.slave bus
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t            state;
  logic [SW-1:0]     settle_cnt;
  logic [CNT_W-1:0]  pattern_cnt;
  logic              done;
  logic              pass_nfail;
  logic [MISR_W-1:0] sig;
  resp_t             resp;
  logic              accept;
  logic              shift;

  assign resp   = '{fz_l: bus.cut_fz_L, lclk: bus.cut_lclk,
                    read_a: bus.cut_read_a, test_out: bus.cut_test_out};
  // Start is only honoured from IDLE/DONE; mid-run and COMPARE-cycle starts are dropped.
  assign accept = bus.start && (state == IDLE || state == DONE);
  assign shift  = bus.resp_valid && (state == COMPACT);

  bist_misr #(
    .MISR_W    (MISR_W),
    .MISR_POLY (MISR_POLY),
    .MISR_SEED (MISR_SEED)
  ) u_misr (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .shift_en (shift),
    .data_in  (resp),
    .sig      (sig)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      pattern_cnt <= '0;
      done        <= 1'b0;
      pass_nfail  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            settle_cnt  <= '0;
            pattern_cnt <= '0;
            done        <= 1'b0;
            pass_nfail  <= 1'b0;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state <= COMPACT;
          else                                     settle_cnt <= settle_cnt + 1'b1;
        end
        COMPACT: begin
          if (bus.resp_valid) begin
            pattern_cnt <= pattern_cnt + 1'b1;
            if (pattern_cnt == CNT_W'(N_PATTERNS - 1)) state <= COMPARE;
          end
        end
        COMPARE: begin
          pass_nfail <= (sig == GOLDEN_SIG);
          done       <= 1'b1;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state == SETTLE) || (state == COMPACT) || (state == COMPARE);
  assign bus.done        = done;
  assign bus.pass_nfail  = pass_nfail;
  assign bus.signature   = sig;
  assign bus.pattern_cnt = pattern_cnt;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Scoreboarded bench: a short-run instance (N=2, golden 0x0002) and a default instance.
module tb_bist_response_analyzer;
  import bist_pkg::*;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    logic [5:0]  cnt;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   dones_a = 0, dones_b = 0;
  logic done_q_a = 1'b0, done_q_b = 1'b0;
  logic [8:0] vec_b [30];

  always #5 clock = ~clock;

  bist_response_analyzer_if #(.MISR_W(16)) a_if ();
  bist_response_analyzer_if #(.MISR_W(16)) b_if ();

  bist_response_analyzer #(
    .N_PATTERNS(2), .SETTLE_CYCLES(1), .MISR_W(16),
    .MISR_POLY(16'h8016), .MISR_SEED(16'h0000), .GOLDEN_SIG(16'h0002)
  ) u_a (.clock(clock), .reset(reset), .bus(a_if.slave));

  bist_response_analyzer u_b (.clock(clock), .reset(reset), .bus(b_if.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [8:0] r);
    logic [15:0] n;
    n = {s[14:0], 1'b0} ^ {7'b0, r};
    if (s[15]) n = n ^ 16'h8016;
    return n;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input logic [8:0] r);
    {a_if.cut_fz_L, a_if.cut_lclk, a_if.cut_read_a, a_if.cut_test_out} = r;
  endtask

  task automatic set_b(input logic [8:0] r);
    {b_if.cut_fz_L, b_if.cut_lclk, b_if.cut_read_a, b_if.cut_test_out} = r;
  endtask

  // Scoreboard monitors: compare the verdict on every rising done.
  always @(negedge clock) begin
    if (a_if.done && !done_q_a) begin
      dones_a++;
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_done actual=1 expected=0");
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_final_sig", a_if.signature, e.sig);
        chk("a_pass_nfail", a_if.pass_nfail, e.pass);
        chk("a_final_cnt", a_if.pattern_cnt, e.cnt);
      end
    end
    done_q_a = a_if.done;
  end

  always @(negedge clock) begin
    if (b_if.done && !done_q_b) begin
      dones_b++;
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_done actual=1 expected=0");
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_final_sig", b_if.signature, e.sig);
        chk("b_pass_nfail", b_if.pass_nfail, e.pass);
        chk("b_final_cnt", b_if.pattern_cnt, e.cnt);
      end
    end
    done_q_b = b_if.done;
  end

  // Two-pattern run on instance a with optional stall and a stray mid-run start.
  task automatic run_a(input logic [8:0] r0, input logic [8:0] r1,
                       input logic [15:0] s0, input logic [15:0] s1,
                       input logic pass, input int stall, input bit start_mid);
    q_a.push_back('{sig: s1, pass: pass, cnt: 6'd2});
    a_if.start = 1'b1; tick(); a_if.start = 1'b0;
    chk("a_start_clears_done", a_if.done, 0);
    chk("a_busy_settle", a_if.busy, 1);
    a_if.resp_valid = 1'b0; tick();
    set_a(r0); a_if.resp_valid = 1'b1; tick();
    chk("a_sig_p0", a_if.signature, s0);
    chk("a_cnt_p0", a_if.pattern_cnt, 1);
    a_if.resp_valid = 1'b0; set_a(9'h1FF);
    repeat (stall) tick();
    if (stall > 0) begin
      chk("a_stall_sig", a_if.signature, s0);
      chk("a_stall_cnt", a_if.pattern_cnt, 1);
    end
    set_a(r1); a_if.resp_valid = 1'b1; a_if.start = start_mid; tick();
    a_if.start = 1'b0; a_if.resp_valid = 1'b0;
    chk("a_sig_p1", a_if.signature, s1);
    chk("a_done_early", a_if.done, 0);
    chk("a_busy_compare", a_if.busy, 1);
    tick();
    chk("a_done_latency", a_if.done, 1);
    chk("a_busy_after", a_if.busy, 0);
    tick();
  endtask

  task automatic run_b();
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 0; i < 30; i++) s = misr_model(s, vec_b[i]);
    q_b.push_back('{sig: s, pass: (s == 16'h0000), cnt: 6'd30});
    b_if.start = 1'b1; tick(); b_if.start = 1'b0;
    chk("b_start_clears_done", b_if.done, 0);
    chk("b_seed_loaded", b_if.signature, 0);
    b_if.resp_valid = 1'b0; tick();
    for (int i = 0; i < 30; i++) begin
      set_b(vec_b[i]); b_if.resp_valid = 1'b1; tick();
    end
    b_if.resp_valid = 1'b0;
    chk("b_done_early", b_if.done, 0);
    tick();
    chk("b_done_latency", b_if.done, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 30; i++) vec_b[i] = 9'((i * 73 + 17) ^ (i << 3));
    reset = 1'b0;
    a_if.start = 1'b0; a_if.resp_valid = 1'b0; set_a(9'h000);
    b_if.start = 1'b0; b_if.resp_valid = 1'b0; set_b(9'h000);
    #3;
    chk("rst_busy", a_if.busy, 0);
    chk("rst_done", a_if.done, 0);
    chk("rst_pass", a_if.pass_nfail, 0);
    chk("rst_sig", a_if.signature, 0);
    chk("rst_cnt", a_if.pattern_cnt, 0);
    chk("rst_b_done", b_if.done, 0);
    tick(); reset = 1'b1; tick();

    run_a(9'h001, 9'h000, 16'h0001, 16'h0002, 1'b1, 0, 1'b0);
    run_a(9'h001, 9'h100, 16'h0001, 16'h0102, 1'b0, 0, 1'b0);
    run_a(9'h001, 9'h000, 16'h0001, 16'h0002, 1'b1, 5, 1'b0);
    run_a(9'h0A5, 9'h13C, 16'h00A5, 16'h0076, 1'b0, 0, 1'b1);
    repeat (3) tick();
    chk("a_single_done_per_run", dones_a, 4);

    // Abort mid-COMPACT with an asynchronous reset.
    q_a.push_back('{sig: 16'h0000, pass: 1'b0, cnt: 6'd0});
    a_if.start = 1'b1; tick(); a_if.start = 1'b0;
    tick();
    set_a(9'h001); a_if.resp_valid = 1'b1; tick();
    chk("abort_sig_before", a_if.signature, 1);
    reset = 1'b0; #1;
    chk("abort_busy", a_if.busy, 0);
    chk("abort_done", a_if.done, 0);
    chk("abort_pass", a_if.pass_nfail, 0);
    chk("abort_sig", a_if.signature, 0);
    chk("abort_cnt", a_if.pattern_cnt, 0);
    void'(q_a.pop_back());
    a_if.resp_valid = 1'b0;
    tick(); reset = 1'b1; tick();
    run_a(9'h001, 9'h000, 16'h0001, 16'h0002, 1'b1, 0, 1'b0);

    run_b();
    run_b();
    repeat (3) tick();
    chk("a_done_count", dones_a, 5);
    chk("b_done_count", dones_b, 2);
    chk("scoreboard_drained", q_a.size() + q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
